// File: rtl/vga_pkg.sv
// Shared VGA constants, brick types and blitter state types.
// Imported by the draw engine and its bench.
package vga_pkg;

  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int SPR_W = 32;
  localparam int SPR_H = 16;
  localparam int NPIX  = SPR_W * SPR_H;

  localparam logic [3:0] TRANSP = 4'h0;

  typedef enum logic [3:0] {
    GREY  = 4'd1,
    BLUE  = 4'd2,
    SHINE = 4'd3,
    TYPE4 = 4'd4
  } brick_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  typedef struct packed {
    logic        vld;
    logic [18:0] addr;
    logic [3:0]  data;
  } fb_wr_t;

endpackage

// File: rtl/brick_blitter.sv
// Brick sprite draw engine: walks the sprite ROM in raster order
// and streams clipped, opaque pixels to the framebuffer port.
module brick_blitter
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_x,
  input  logic [8:0]  req_y,
  input  logic [3:0]  req_type,
  output logic [18:0] rom_addr,
  output logic [3:0]  rom_type,
  input  logic [3:0]  rom_data,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [3:0]  fb_data,
  input  logic        fb_ready,
  output logic        busy,
  output logic        done
);

  state_t      state_q, state_d;
  logic [4:0]  col_q, col_d;
  logic [3:0]  row_q, row_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [3:0]  type_q, type_d;
  fb_wr_t      b_q, b_d;
  logic        done_q, done_d;

  logic        stall;
  logic        last;
  logic        vis;
  logic [10:0] sx;
  logic [9:0]  sy;
  logic [18:0] pix;

  assign stall = b_q.vld & ~fb_ready;
  assign last  = (col_q == 5'(SPR_W - 1))
               & (row_q == 4'(SPR_H - 1));

  assign sx = {1'b0, x_q} + {6'b0, col_q};
  assign sy = {1'b0, y_q} + {6'b0, row_q};

  // Clip on the unwrapped coordinates, truncate only the final address
  assign vis = (sx < 11'(SCR_W))
             & (sy < 10'(SCR_H))
             & (rom_data != TRANSP);
  assign pix = 19'(32'(sy) * 32'(SCR_W)
             + 32'(sx));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    x_d     = x_q;
    y_d     = y_q;
    type_d  = type_q;
    b_d     = b_q;
    done_d  = 1'b0;
    if (b_q.vld && fb_ready) begin
      b_d.vld = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          x_d     = req_x;
          y_d     = req_y;
          type_d  = req_type;
          col_d   = '0;
          row_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (!stall) begin
          b_d.vld = vis;
          if (vis) begin
            b_d.addr = pix;
            b_d.data = rom_data;
          end
          col_d = col_q + 5'd1;
          if (col_q == 5'(SPR_W - 1)) begin
            row_d = row_q + 4'd1;
          end
          if (last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!b_q.vld || fb_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      type_q  <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      x_q     <= x_d;
      y_q     <= y_d;
      type_q  <= type_d;
      b_q     <= b_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr  = 19'(row_q) * 19'(SPR_W)
                   + 19'(col_q);
  assign rom_type  = type_q;
  assign fb_we     = b_q.vld;
  assign fb_addr   = b_q.addr;
  assign fb_data   = b_q.data;
  assign busy      = (state_q != IDLE);
  assign req_ready = (state_q == IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_brick_blitter.sv
// Directed scoreboard bench for the brick sprite draw engine.
// Expected writes are queued at request time and popped on output.
module tb_brick_blitter;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_x;
  logic [8:0]  req_y;
  logic [3:0]  req_type;
  logic [18:0] rom_addr;
  logic [3:0]  rom_type;
  logic [3:0]  rom_data;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [3:0]  fb_data;
  logic        fb_ready;
  logic        busy;
  logic        done;

  brick_blitter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_type  (req_type),
    .rom_addr  (rom_addr),
    .rom_type  (rom_type),
    .rom_data  (rom_data),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_ready  (fb_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int rom_mode;

  function automatic logic [3:0] rom_fn(
    logic [18:0] a, int m);
    case (m)
      0: return 4'h5;
      1: return a[0] ? 4'h9 : 4'h0;
      default:
        return (a[3:0] == 4'h0) ? 4'hc : a[3:0];
    endcase
  endfunction

  always_comb rom_data = rom_fn(rom_addr, rom_mode);

  typedef struct {
    logic [18:0] a;
    logic [3:0]  d;
  } wr_t;

  wr_t sb[$];

  int errors;
  int checks;
  int cyc;
  int acc;
  int wr_cnt;
  int done_cnt;
  int done_cyc;
  int stall_idx;
  int stall_left;
  int stall_rom;
  int exp_n;
  logic [18:0] last_addr;

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_job(int x, int y, int m);
    int a;
    logic [3:0] d;
    exp_n = 0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 32; c++) begin
        a = r * 32 + c;
        d = rom_fn(19'(a), m);
        if (d != 4'h0 && x + c < 640 && y + r < 480) begin
          sb.push_back('{19'((y + r) * 640 + x + c), d});
          exp_n++;
        end
      end
    end
  endtask

  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    cyc++;
    fb_ready = 1'b1;
    if (fb_we && wr_cnt == stall_idx && stall_left > 0) begin
      fb_ready = 1'b0;
      stall_left--;
      if (sb.size() == 0) begin
        chk("stall_pending", 0, 1);
      end else begin
        chk("stall_addr", 32'(fb_addr), 32'(sb[0].a));
        chk("stall_data", 32'(fb_data), 32'(sb[0].d));
      end
      chk("stall_rom", 32'(rom_addr), 32'(stall_rom));
    end
    if (fb_we && fb_ready) begin
      if (sb.size() == 0) begin
        chk("extra_write", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(fb_addr), 32'(e.a));
        chk("wr_data", 32'(fb_data), 32'(e.d));
        last_addr = fb_addr;
      end
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic start_job(int x, int y, int t, int m);
    rom_mode  = m;
    push_job(x, y, m);
    req_x     = 10'(x);
    req_y     = 9'(y);
    req_type  = 4'(t);
    req_valid = 1'b1;
    wr_cnt    = 0;
    done_cnt  = 0;
    step();
    req_valid = 1'b0;
    acc = cyc;
    chk("start_rom_addr", 32'(rom_addr), 0);
    chk("start_busy", 32'(busy), 1);
    chk("start_ready", 32'(req_ready), 0);
    chk("start_type", 32'(rom_type), 32'(t));
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic finish_job(int extra);
    chk("done_cyc", 32'(done_cyc), 32'(acc + 513 + extra));
    chk("writes", 32'(wr_cnt), 32'(exp_n));
    chk("sb_empty", 32'(sb.size()), 0);
    chk("done_ready", 32'(req_ready), 1);
    step();
    chk("done_pulse", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    cyc        = 0;
    stall_idx  = -1;
    stall_left = 0;
    stall_rom  = 0;
    rom_mode   = 0;
    req_valid  = 1'b0;
    req_x      = '0;
    req_y      = '0;
    req_type   = '0;
    fb_ready   = 1'b1;
    #2;
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_data", 32'(fb_data), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_rom_type", 32'(rom_type), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(req_ready), 1);
    #10;
    rst_n = 1'b1;
    step();

    start_job(0, 0, GREY, 0);
    chk("first_we_low", 32'(fb_we), 0);
    step();
    chk("first_we", 32'(fb_we), 1);
    wait_done(700);
    chk("last_full", 32'(last_addr), 9631);
    finish_job(0);

    start_job(620, 470, BLUE, 0);
    wait_done(700);
    chk("clip_n", 32'(wr_cnt), 200);
    chk("clip_last", 32'(last_addr), 307199);
    finish_job(0);

    start_job(10, 20, SHINE, 1);
    wait_done(700);
    chk("transp_n", 32'(wr_cnt), 256);
    finish_job(0);

    start_job(700, 10, TYPE4, 0);
    wait_done(700);
    chk("offscr_n", 32'(wr_cnt), 0);
    finish_job(0);

    stall_idx  = 4;
    stall_left = 3;
    stall_rom  = 5;
    start_job(0, 0, GREY, 0);
    wait_done(700);
    chk("stall_used", 32'(stall_left), 0);
    finish_job(3);
    stall_idx = -1;

    start_job(100, 50, BLUE, 0);
    for (int i = 0; i < 10; i++) step();
    req_x     = 10'd5;
    req_y     = 9'd5;
    req_type  = SHINE;
    req_valid = 1'b1;
    step();
    chk("busy_ready", 32'(req_ready), 0);
    chk("busy_type", 32'(rom_type), 32'(BLUE));
    wait_done(700);
    chk("a_done_cyc", 32'(done_cyc), 32'(acc + 513));
    chk("a_writes", 32'(wr_cnt), 512);
    chk("a_ready", 32'(req_ready), 1);
    push_job(5, 5, 0);
    wr_cnt   = 0;
    done_cnt = 0;
    step();
    req_valid = 1'b0;
    acc = cyc;
    chk("b_rom_addr", 32'(rom_addr), 0);
    chk("b_type", 32'(rom_type), 32'(SHINE));
    chk("b_done_low", 32'(done), 0);
    wait_done(700);
    finish_job(0);

    start_job(0, 0, GREY, 2);
    for (int n = 0; n < 300 && rom_addr != 19'd100; n++) step();
    chk("reach_100", 32'(rom_addr), 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(fb_we), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(req_ready), 1);
    chk("abort_rom", 32'(rom_addr), 0);
    sb.delete();
    done_cnt = 0;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("abort_nodone", 32'(done_cnt), 0);
    chk("abort_idle_we", 32'(fb_we), 0);

    start_job(40, 200, TYPE4, 2);
    wait_done(700);
    finish_job(0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/brick_blitter.md
Name: brick_blitter

Overview:
- Draw engine that initiates reads on the brick sprite ROM.
- Accepts one draw request (screen x/y plus brick type) and walks the SPR_W x SPR_H sprite in raster order.
- Each pixel: presents the ROM address and type, collects the 4-bit palette index, and issues a framebuffer write with ready back-pressure.
- Sits between game control (request source) and the VGA framebuffer write port.

Parameters:
- SPR_W, 32, sprite width in pixels.
- SPR_H, 16, sprite height in pixels; SPR_W*SPR_H = 512 matches ROM depth.
- SCR_W, 640, screen width; framebuffer row stride.
- SCR_H, 480, screen height.
- TRANSP, 4'h0, palette index treated as transparent (never written).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  draw request valid
- req_ready  out  1  block can accept a request
- req_x  in  10  sprite top-left x
- req_y  in  9  sprite top-left y
- req_type  in  4  brick type forwarded to ROM
- rom_addr  out  19  ROM read address (row*SPR_W+col)
- rom_type  out  4  brick type to ROM
- rom_data  in  4  ROM palette index; combinational, valid in the same cycle as rom_addr
- fb_we  out  1  framebuffer write valid
- fb_addr  out  19  framebuffer pixel address
- fb_data  out  4  palette index to write
- fb_ready  in  1  framebuffer accepts write this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset is asynchronous, active-low, on rst_n; the clock is clk.
- Reset values:
  - state=IDLE; col=row=0; stage-B valid=0.
  - fb_we=0, fb_addr=0, fb_data=0.
  - rom_addr=0, rom_type=0.
  - busy=0, done=0, req_ready=1.
- States:
  - IDLE: req_ready=1. On req_valid, latch x, y, type; clear col/row; go to FETCH.
  - FETCH: rom_addr = row*SPR_W+col; rom_type = latched type. Each non-stalled cycle captures rom_data into stage B and advances col (wrap to 0, row++). After issuing pixel SPR_W*SPR_H-1, go to DRAIN.
  - DRAIN: hold until stage B is empty. Then go to IDLE, asserting done for exactly one cycle (the first IDLE cycle).
- req_ready=0 outside IDLE. Requests are never queued; req_valid while busy is ignored.
- Pipeline is two stages: A (address/ROM), B (registered write).
  - Stage B loads a pixel only if the pixel is opaque (rom_data != TRANSP) and on screen: (x+col) < SCR_W and (y+row) < SCR_H.
  - Otherwise the pixel is consumed with no write.
- fb_we = stage-B valid.
  - fb_addr = (y+row)*SCR_W + (x+col), computed at full width, truncated to 19 bits only after the clip check.
  - fb_addr and fb_data are held stable while fb_we=1 and fb_ready=0.
- Stall condition: stage-B valid and !fb_ready.
  - Stage A does not advance and rom_addr is held.
  - A write completes on a cycle with fb_we and fb_ready both high.
- Latency: unstalled and all opaque, request accepted at edge k gives:
  - rom_addr 0..511 in cycles k+1..k+512
  - fb_we in cycles k+2..k+513
  - done in cycle k+514
- rom_type stays constant for a whole job. The animated type (3) may change frames mid-job; this is accepted.
- Fully clipped or fully transparent sprite: zero writes, done still at k+514.
- Reset mid-job aborts immediately: no further writes, no done.

Decomposition:
- Shared package vga_pkg:
  - SCR_W, SCR_H, SPR_W, SPR_H
  - brick type enum (GREY=1, BLUE=2, SHINE=3, TYPE4=4)
  - TRANSP
  - state typedef {IDLE, FETCH, DRAIN}
- No sub-module needed. An optional fb_addr_gen (incremental row-base adder, avoids a multiplier) is acceptable.

Test Plan:
- Request x=0, y=0, type=1, ROM data all 5, fb_ready=1 -> 512 writes, fb_addr 0..31, 640..671, ..., 9600..9631; fb_data=5; done at cycle k+514.
- Request x=620, y=470, all opaque -> only cols 0..19 and rows 0..9 write (200 writes). Last fb_addr=479*640+639=307199. done still pulses.
- ROM returns TRANSP at even addresses -> exactly 256 writes, odd pixels only. Timing of done unchanged.
- fb_ready low for 3 cycles on the 5th write -> fb_we/fb_addr/fb_data held; rom_addr frozen at 5; no pixel lost or duplicated; done delayed by 3 cycles.
- Second req_valid during a job -> req_ready=0, request ignored. New request accepted on the first IDLE cycle, the same cycle done pulses.
- rst_n low at pixel 100 -> fb_we=0, busy=0, req_ready=1 asynchronously. No done pulse; the next request restarts at rom_addr 0.
